clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Button-driven time-setting controller and port arbiter for the HH:MM timer. Sequences a set-time session from two push-buttons (mode, up), holds an edited shadow copy of hours/minutes, then commits it to the timer through the timer's CPU register port. Owns that port, sharing it between the CPU and its own commit sequence.

## Interface
- DEBOUNCE_CYCLES, 1000000: stable-level cycles before a button change is accepted (20 ms at 50 MHz).
- REPEAT_CYCLES, 12500000: auto-repeat period while up is held (250 ms).
- TIMEOUT_CYCLES, 500000000: idle time in an edit state before the session is abandoned (10 s).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high.
- btn_mode, btn_up  in  1 each  raw asynchronous buttons, active-high.
- cur_hour1[1:0], cur_hour0[3:0], cur_min1[2:0], cur_min0[3:0]  in  current BCD time from the timer.
- cpu_sel, cpu_we  in  1 each  CPU access request to the timer.
- cpu_addr  in  2  timer register: 0=MIN0, 1=MIN1, 2=HOUR0, 3=HOUR1.
- cpu_wdata  in  4  CPU write data.
- cpu_busy  out  1  high while the commit sequence owns the port.
- tmr_sel, tmr_we  out  1 each  to timer sel / write_en.
- tmr_addr  out  2  to timer address, same encoding as cpu_addr.
- tmr_wdata  out  4  to timer data_in.
- editing  out  1  high in EDIT_HOUR/EDIT_MIN.
- edit_field  out  2  0=none, 1=hours, 2=minutes.
- disp_hour1[1:0], disp_hour0[3:0], disp_min1[2:0], disp_min0[3:0]  out  shadow digits while editing, cur_* otherwise (combinational mux).

## Operation
- Button path: 2-FF synchronizer, then per-button debounce counter; debounced rising edge gives a one-cycle press pulse. Up held past REPEAT_CYCLES after press emits one extra pulse every REPEAT_CYCLES until release.
- FSM states: IDLE, EDIT_HOUR, EDIT_MIN, C_H1, C_H0, C_M1, C_M0.
- IDLE: mode pulse -> copy cur_* into shadow, go EDIT_HOUR. Up pulses ignored.
- EDIT_HOUR: up pulse increments shadow hour BCD; 09->10, 19->20, 23->00. Mode pulse -> EDIT_MIN.
- EDIT_MIN: up pulse increments shadow minute BCD; 09->10, 59->00, no carry into hours. Mode pulse -> C_H1.
- Mode and up pulse in the same cycle: mode acts, up discarded.
- Timeout counter clears on entry to an edit state and on every press pulse; reaching TIMEOUT_CYCLES-1 -> IDLE, no writes, shadow discarded.
- Commit: C_H1, C_H0, C_M1, C_M0 each last exactly one cycle and issue one write (sel=we=1) of shadow HOUR1 (zero-extended), HOUR0, MIN1 (zero-extended), MIN0, then IDLE. Button pulses ignored during commit.
- Arbitration: outside commit, cpu_* forwarded to tmr_*; in commit states cpu_busy=1 and CPU requests are dropped, not queued. Commit always has priority.

## Timing
- All tmr_* and cpu_busy registered: CPU request at edge N appears on tmr_* after edge N+1 (one-cycle latency).
- First commit write on tmr_* the cycle after the mode pulse in EDIT_MIN; four consecutive write cycles; cpu_busy high exactly those four cycles; CPU forwarding resumes the following cycle.
- Press pulse lags a clean button edge by 2 sync + DEBOUNCE_CYCLES cycles; bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Reset values: tmr_sel=tmr_we=0, tmr_addr=0, tmr_wdata=0, cpu_busy=0, editing=0, edit_field=0, FSM=IDLE, shadow=00:00, all counters 0.
- Reset mid-commit: write stops next edge; writes already issued stay in the timer; no resume.

## Test plan
- Reset, then CPU write addr=2 data=5 at cycle N -> tmr_sel=tmr_we=1, addr=2, data=5 at cycle N+1; cpu_busy=0.
- cur=22:58, mode, up x2, mode, up x3, mode -> disp shows 00:01 before commit; writes HOUR1=0, HOUR0=0, MIN1=0, MIN0=1 on four consecutive cycles, cpu_busy high those four cycles only.
- CPU write asserted during commit -> not forwarded; next CPU write after commit forwarded normally.
- Up held 3*REPEAT_CYCLES from minute 58 -> press plus 3 repeats: 58->59->00->01->02; hours unchanged.
- Mode press, no further input for TIMEOUT_CYCLES -> IDLE, editing=0, no tmr write.
- Mode and up pulses coincident in EDIT_HOUR -> moves to EDIT_MIN, hour unchanged; 100-cycle bounce on btn_up (DEBOUNCE_CYCLES=16 sim) -> exactly one pulse.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Register-port bundle between the CPU, the set-time controller and the HH:MM timer.
// master = controller (arbiter) side, slave = CPU/timer side.
interface clock_set_ctrl_if;
    logic       cpu_sel;
    logic       cpu_we;
    logic [1:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_busy;
    logic       tmr_sel;
    logic       tmr_we;
    logic [1:0] tmr_addr;
    logic [3:0] tmr_wdata;

    modport master (
        input  cpu_sel, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, tmr_sel, tmr_we, tmr_addr, tmr_wdata
    );

    modport slave (
        output cpu_sel, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, tmr_sel, tmr_we, tmr_addr, tmr_wdata
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Push-button set-time session for the HH:MM timer: debounced mode/up buttons edit a
// shadow time, which is then committed through the timer register port shared with the CPU.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_btn_mode,
    input  logic                    i_btn_up,
    input  logic [1:0]              i_cur_hour1,
    input  logic [3:0]              i_cur_hour0,
    input  logic [2:0]              i_cur_min1,
    input  logic [3:0]              i_cur_min0,
    clock_set_ctrl_if.master        bus,
    output logic                    o_editing,
    output logic [1:0]              o_edit_field,
    output logic [1:0]              o_disp_hour1,
    output logic [3:0]              o_disp_hour0,
    output logic [2:0]              o_disp_min1,
    output logic [3:0]              o_disp_min0
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EDIT_HOUR = 3'd1;
    localparam logic [2:0] S_EDIT_MIN  = 3'd2;
    localparam logic [2:0] S_C_H1      = 3'd3;
    localparam logic [2:0] S_C_H0      = 3'd4;
    localparam logic [2:0] S_C_M1      = 3'd5;
    localparam logic [2:0] S_C_M0      = 3'd6;

    localparam logic [1:0] ADDR_MIN0  = 2'd0;
    localparam logic [1:0] ADDR_MIN1  = 2'd1;
    localparam logic [1:0] ADDR_HOUR0 = 2'd2;
    localparam logic [1:0] ADDR_HOUR1 = 2'd3;

    // ---------------------------------------------------------------
    // Button conditioning: bit 0 = mode, bit 1 = up
    // ---------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_db;
    logic [1:0] w_rise;

    assign w_btn_raw = {i_btn_up, i_btn_mode};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_btn
            logic [1:0]      r_sync;
            logic            r_db;
            logic            r_db_d;
            logic [DB_W-1:0] r_cnt;

            // A level change is accepted only after it has held for DEBOUNCE_CYCLES.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                    r_db   <= 1'b0;
                    r_db_d <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_btn_raw[gi]};
                    r_db_d <= r_db;
                    if (r_sync[1] == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_db  <= r_sync[1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_db[gi]   = r_db;
            assign w_rise[gi] = r_db & ~r_db_d;
        end
    endgenerate

    // Auto-repeat: the counter is zero on the press cycle, so it reaches
    // REPEAT_CYCLES exactly one period after each pulse and restarts at 1.
    logic [RP_W-1:0] r_rep_cnt;
    logic            w_rep_pulse;

    always_ff @(posedge clk) begin
        if (rst || !w_db[1]) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt == RP_W'(REPEAT_CYCLES)) begin
            r_rep_cnt <= RP_W'(1);
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_rep_pulse = w_db[1] && (r_rep_cnt == RP_W'(REPEAT_CYCLES));

    logic w_mode_pulse;
    logic w_up_pulse;

    assign w_mode_pulse = w_rise[0];
    assign w_up_pulse   = w_rise[1] | w_rep_pulse;

    // ---------------------------------------------------------------
    // Shadow time and BCD increment
    // ---------------------------------------------------------------
    logic [1:0] r_sh_h1;
    logic [3:0] r_sh_h0;
    logic [2:0] r_sh_m1;
    logic [3:0] r_sh_m0;

    logic [1:0] w_inc_h1;
    logic [3:0] w_inc_h0;
    logic [2:0] w_inc_m1;
    logic [3:0] w_inc_m0;

    always_comb begin
        w_inc_h1 = r_sh_h1;
        w_inc_h0 = r_sh_h0 + 4'd1;
        if (r_sh_h1 == 2'd2 && r_sh_h0 == 4'd3) begin
            w_inc_h1 = 2'd0;
            w_inc_h0 = 4'd0;
        end else if (r_sh_h0 == 4'd9) begin
            w_inc_h1 = r_sh_h1 + 2'd1;
            w_inc_h0 = 4'd0;
        end
    end

    always_comb begin
        w_inc_m1 = r_sh_m1;
        w_inc_m0 = r_sh_m0 + 4'd1;
        if (r_sh_m0 == 4'd9) begin
            w_inc_m0 = 4'd0;
            w_inc_m1 = (r_sh_m1 == 3'd5) ? 3'd0 : r_sh_m1 + 3'd1;
        end
    end

    // ---------------------------------------------------------------
    // Session FSM
    // ---------------------------------------------------------------
    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_edit_now;

    logic [1:0] w_sh_h1_next;
    logic [3:0] w_sh_h0_next;
    logic [2:0] w_sh_m1_next;
    logic [3:0] w_sh_m0_next;

    assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_edit_now = (r_state == S_EDIT_HOUR) || (r_state == S_EDIT_MIN);

    // Mode is checked before up everywhere, so a coincident up pulse is discarded.
    always_comb begin
        w_state_next = r_state;
        w_sh_h1_next = r_sh_h1;
        w_sh_h0_next = r_sh_h0;
        w_sh_m1_next = r_sh_m1;
        w_sh_m0_next = r_sh_m0;
        case (r_state)
            S_IDLE: begin
                if (w_mode_pulse) begin
                    w_sh_h1_next = i_cur_hour1;
                    w_sh_h0_next = i_cur_hour0;
                    w_sh_m1_next = i_cur_min1;
                    w_sh_m0_next = i_cur_min0;
                    w_state_next = S_EDIT_HOUR;
                end
            end
            S_EDIT_HOUR: begin
                if (w_mode_pulse) begin
                    w_state_next = S_EDIT_MIN;
                end else if (w_up_pulse) begin
                    w_sh_h1_next = w_inc_h1;
                    w_sh_h0_next = w_inc_h0;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_EDIT_MIN: begin
                if (w_mode_pulse) begin
                    w_state_next = S_C_H1;
                end else if (w_up_pulse) begin
                    w_sh_m1_next = w_inc_m1;
                    w_sh_m0_next = w_inc_m0;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_C_H1:  w_state_next = S_C_H0;
            S_C_H0:  w_state_next = S_C_M1;
            S_C_M1:  w_state_next = S_C_M0;
            S_C_M0:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh_h1 <= '0;
            r_sh_h0 <= '0;
            r_sh_m1 <= '0;
            r_sh_m0 <= '0;
        end else begin
            r_state <= w_state_next;
            r_sh_h1 <= w_sh_h1_next;
            r_sh_h0 <= w_sh_h0_next;
            r_sh_m1 <= w_sh_m1_next;
            r_sh_m0 <= w_sh_m0_next;
        end
    end

    // Idle timer: restarts on every state change and on every press pulse.
    always_ff @(posedge clk) begin
        if (rst || !w_edit_now || (w_state_next != r_state) || w_mode_pulse || w_up_pulse) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Port arbiter: outputs are loaded from the next state so that each commit
    // write is on tmr_* during the cycle its commit state is current.
    // ---------------------------------------------------------------
    logic       r_tmr_sel;
    logic       r_tmr_we;
    logic [1:0] r_tmr_addr;
    logic [3:0] r_tmr_wdata;
    logic       r_cpu_busy;

    logic       w_tmr_sel;
    logic       w_tmr_we;
    logic [1:0] w_tmr_addr;
    logic [3:0] w_tmr_wdata;
    logic       w_busy;

    always_comb begin
        w_busy      = 1'b1;
        w_tmr_sel   = 1'b1;
        w_tmr_we    = 1'b1;
        w_tmr_addr  = ADDR_MIN0;
        w_tmr_wdata = r_sh_m0;
        case (w_state_next)
            S_C_H1: begin
                w_tmr_addr  = ADDR_HOUR1;
                w_tmr_wdata = {2'b00, r_sh_h1};
            end
            S_C_H0: begin
                w_tmr_addr  = ADDR_HOUR0;
                w_tmr_wdata = r_sh_h0;
            end
            S_C_M1: begin
                w_tmr_addr  = ADDR_MIN1;
                w_tmr_wdata = {1'b0, r_sh_m1};
            end
            S_C_M0: begin
                w_tmr_addr  = ADDR_MIN0;
                w_tmr_wdata = r_sh_m0;
            end
            default: begin
                w_busy      = 1'b0;
                w_tmr_sel   = bus.cpu_sel;
                w_tmr_we    = bus.cpu_we;
                w_tmr_addr  = bus.cpu_addr;
                w_tmr_wdata = bus.cpu_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr_sel   <= 1'b0;
            r_tmr_we    <= 1'b0;
            r_tmr_addr  <= '0;
            r_tmr_wdata <= '0;
            r_cpu_busy  <= 1'b0;
        end else begin
            r_tmr_sel   <= w_tmr_sel;
            r_tmr_we    <= w_tmr_we;
            r_tmr_addr  <= w_tmr_addr;
            r_tmr_wdata <= w_tmr_wdata;
            r_cpu_busy  <= w_busy;
        end
    end

    assign bus.tmr_sel   = r_tmr_sel;
    assign bus.tmr_we    = r_tmr_we;
    assign bus.tmr_addr  = r_tmr_addr;
    assign bus.tmr_wdata = r_tmr_wdata;
    assign bus.cpu_busy  = r_cpu_busy;

    // ---------------------------------------------------------------
    // Status and display
    // ---------------------------------------------------------------
    assign o_editing    = w_edit_now;
    assign o_edit_field = (r_state == S_EDIT_HOUR) ? 2'd1 :
                          (r_state == S_EDIT_MIN)  ? 2'd2 : 2'd0;

    assign o_disp_hour1 = w_edit_now ? r_sh_h1 : i_cur_hour1;
    assign o_disp_hour0 = w_edit_now ? r_sh_h0 : i_cur_hour0;
    assign o_disp_min1  = w_edit_now ? r_sh_m1 : i_cur_min1;
    assign o_disp_min0  = w_edit_now ? r_sh_m0 : i_cur_min0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/timeout constants;
// expected values are hand-computed BCD times and register writes.
module tb_clock_set_ctrl;

    localparam int DEB = 16;
    localparam int REP = 64;
    localparam int TO  = 600;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_up;
    logic [1:0] cur_hour1;
    logic [3:0] cur_hour0;
    logic [2:0] cur_min1;
    logic [3:0] cur_min0;
    logic       editing;
    logic [1:0] edit_field;
    logic [1:0] disp_hour1;
    logic [3:0] disp_hour0;
    logic [2:0] disp_min1;
    logic [3:0] disp_min0;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_mode   (btn_mode),
        .i_btn_up     (btn_up),
        .i_cur_hour1  (cur_hour1),
        .i_cur_hour0  (cur_hour0),
        .i_cur_min1   (cur_min1),
        .i_cur_min0   (cur_min0),
        .bus          (bus),
        .o_editing    (editing),
        .o_edit_field (edit_field),
        .o_disp_hour1 (disp_hour1),
        .o_disp_hour0 (disp_hour0),
        .o_disp_min1  (disp_min1),
        .o_disp_min0  (disp_min0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tmr_sel === 1'b1 && bus.tmr_we === 1'b1) wr_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %-14s got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
            $display("ok   %-14s 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [12:0] hm(input int h1, input int h0, input int m1, input int m0);
        return {2'(h1), 4'(h0), 3'(m1), 4'(m0)};
    endfunction

    function automatic logic [12:0] disp_now();
        return {disp_hour1, disp_hour0, disp_min1, disp_min0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
        {cur_hour1, cur_hour0, cur_min1, cur_min0} = hm(h1, h0, m1, m0);
    endtask

    // sel 0 = mode, 1 = up; clean press long enough to debounce in and out
    task automatic press(input int sel);
        if (sel == 0) btn_mode = 1'b1; else btn_up = 1'b1;
        tick(DEB + 8);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(DEB + 8);
    endtask

    // CPU write at edge N must show on tmr_* only after edge N+1
    task automatic cpu_write_check(input string tag, input int addr, input int data);
        @(posedge clk); #1;
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 2'(addr); bus.cpu_wdata = 4'(data);
        @(negedge clk);
        check_val({tag, "_lat"}, 32'(bus.tmr_sel), 0);
        @(posedge clk); #1;
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0;
        @(negedge clk);
        check_val({tag, "_fwd"}, {bus.tmr_sel, bus.tmr_we, bus.cpu_busy, bus.tmr_addr, bus.tmr_wdata},
                  {1'b1, 1'b1, 1'b0, 2'(addr), 4'(data)});
    endtask

    task automatic wait_busy(output bit found);
        found = 1'b0;
        for (int i = 0; i < DEB + 40 && !found; i++) begin
            @(negedge clk);
            found = (bus.cpu_busy === 1'b1);
        end
        check_val("busy_seen", 32'(found), 1);
    endtask

    // Press mode in EDIT_MIN and follow the four commit writes; a CPU write is
    // presented during the commit and must be dropped.
    task automatic commit_check(input int h1, input int h0, input int m1, input int m0);
        bit       found;
        int       exp_addr [4];
        int       exp_data [4];
        exp_addr = '{3, 2, 1, 0};
        exp_data = '{h1, h0, m1, m0};
        btn_mode = 1'b1;
        wait_busy(found);
        if (found) begin
            for (int k = 0; k < 4; k++) begin
                check_val($sformatf("commit_w%0d", k),
                          {bus.tmr_sel, bus.tmr_we, bus.cpu_busy, bus.tmr_addr, bus.tmr_wdata},
                          {1'b1, 1'b1, 1'b1, 2'(exp_addr[k]), 4'(exp_data[k])});
                if (k == 0) begin
                    bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1;
                    bus.cpu_addr = 2'd1; bus.cpu_wdata = 4'd7;
                end
                if (k == 2) begin
                    bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0;
                end
                @(negedge clk);
            end
            check_val("commit_after", {bus.cpu_busy, bus.tmr_sel}, 0);
        end
        btn_mode = 1'b0;
        tick(DEB + 8);
    endtask

    initial begin
        bit found;
        int wr0;

        rst = 1'b1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_addr = 2'd0; bus.cpu_wdata = 4'd0;
        set_cur(1, 2, 3, 4);
        tick(5);

        // reset state
        @(negedge clk);
        check_val("rst_tmr", {bus.tmr_sel, bus.tmr_we, bus.tmr_addr, bus.tmr_wdata}, 0);
        check_val("rst_busy", 32'(bus.cpu_busy), 0);
        check_val("rst_editing", {editing, edit_field}, 0);
        check_val("rst_disp", 32'(disp_now()), 32'(hm(1, 2, 3, 4)));
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        cpu_write_check("cpu1", 2, 5);

        // 22:58 -> hours +2 -> 00, minutes +3 -> 01
        set_cur(2, 2, 5, 8);
        press(0);
        check_val("enter_hour", {editing, edit_field}, {1'b1, 2'd1});
        check_val("shadow_copy", 32'(disp_now()), 32'(hm(2, 2, 5, 8)));
        press(1);
        press(1);
        check_val("hour_wrap", 32'(disp_now()), 32'(hm(0, 0, 5, 8)));
        press(0);
        check_val("enter_min", 32'(edit_field), 2);
        press(1);
        press(1);
        press(1);
        check_val("min_wrap", 32'(disp_now()), 32'(hm(0, 0, 0, 1)));
        commit_check(0, 0, 0, 1);
        check_val("post_commit", {editing, edit_field}, 0);
        cpu_write_check("cpu2", 0, 9);

        // held up: press plus three repeats, 58 -> 02, hours untouched
        set_cur(1, 4, 5, 8);
        press(0);
        press(0);
        btn_up = 1'b1;
        tick(3 * REP + 20);
        btn_up = 1'b0;
        tick(DEB + 8);
        check_val("repeat_min", 32'(disp_now()), 32'(hm(1, 4, 0, 2)));

        // abandon by timeout: no writes, display falls back to cur
        wr0 = wr_count;
        tick(TO / 2);
        check_val("to_not_yet", 32'(editing), 1);
        found = 1'b0;
        for (int i = 0; i < TO + 20 && !found; i++) begin
            @(negedge clk);
            found = (editing === 1'b0);
        end
        check_val("to_expired", 32'(found), 1);
        check_val("to_no_write", 32'(wr_count - wr0), 0);
        check_val("to_disp", {18'(edit_field), disp_now()}, {18'd0, hm(1, 4, 5, 8)});

        // coincident mode+up in EDIT_HOUR: mode wins, hour unchanged
        set_cur(0, 7, 3, 0);
        press(0);
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        tick(DEB + 8);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(DEB + 8);
        check_val("coinc_field", 32'(edit_field), 2);
        check_val("coinc_disp", 32'(disp_now()), 32'(hm(0, 7, 3, 0)));

        // bounce shorter than the debounce window, then settle high: one increment
        for (int i = 0; i < 10; i++) begin
            btn_up = 1'b1; tick(5);
            btn_up = 1'b0; tick(5);
        end
        check_val("bounce_none", 32'(disp_now()), 32'(hm(0, 7, 3, 0)));
        btn_up = 1'b1;
        tick(DEB + 8);
        btn_up = 1'b0;
        tick(DEB + 8);
        check_val("bounce_one", 32'(disp_now()), 32'(hm(0, 7, 3, 1)));

        // reset during the first commit write stops the sequence
        btn_mode = 1'b1;
        wait_busy(found);
        rst = 1'b1;
        btn_mode = 1'b0;
        @(negedge clk);
        check_val("rst_mid_commit", {bus.tmr_sel, bus.tmr_we, bus.cpu_busy, editing}, 0);
        rst = 1'b0;
        tick(10);
        check_val("rst_no_resume", {bus.tmr_sel, bus.cpu_busy, editing}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
